// File: rtl/piano_pkg.sv
// Shared piano definitions: note codes and tone half-period table.
// Used by the keyboard front end and the song-guide FSMs so note codes agree.
package piano_pkg;

    localparam int NOTE_W = 4;
    localparam int TONE_W = 18;

    typedef logic [NOTE_W-1:0] note_t;

    localparam note_t NOTE_NONE = 4'd0;
    localparam note_t NOTE_C4   = 4'd1;
    localparam note_t NOTE_D    = 4'd2;
    localparam note_t NOTE_E    = 4'd3;
    localparam note_t NOTE_F    = 4'd4;
    localparam note_t NOTE_G    = 4'd5;
    localparam note_t NOTE_A    = 4'd6;
    localparam note_t NOTE_B    = 4'd7;
    localparam note_t NOTE_C5   = 4'd8;

    // Half-period in clock cycles at 100 MHz, divided by scale and floored to at least 1.
    function automatic logic [TONE_W-1:0] half_period(input note_t n, input int scale);
        int base;
        int h;
        case (n)
            NOTE_C4: base = 191110;
            NOTE_D:  base = 170265;
            NOTE_E:  base = 151685;
            NOTE_F:  base = 143172;
            NOTE_G:  base = 127551;
            NOTE_A:  base = 113636;
            NOTE_B:  base = 101239;
            NOTE_C5: base = 95557;
            default: base = 0;
        endcase
        h = base / ((scale < 1) ? 1 : scale);
        if (h < 1) h = 1;
        return TONE_W'(h);
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability counter; commit pulses once per
// cycle while the candidate vector has been stable long enough.
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] cand,
    output logic             commit
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] dcnt;

    // commit is registered, so note lands one edge after the counter saturates.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            dcnt   <= '0;
            commit <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            commit <= 1'b0;
            if (s2 != cand) begin
                cand <= s2;
                dcnt <= '0;
            end else if (dcnt == CNT_LAST) begin
                commit <= 1'b1;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piano_keyboard.sv
// Piano front end: debounced key encoding, note change strobe and square-wave tone.
// Build option PIANO_CHORD_PRIORITY_EN: multi-key vectors pick the lowest-index key.
module piano_keyboard
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TONE_SCALE      = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        sw,
    output logic [NOTE_W-1:0] note,
    output logic              note_strobe,
    output logic              FREQ
);

    logic [7:0]        cand;
    logic              commit;
    note_t             enc;
    logic              change;
    logic [TONE_W-1:0] tcnt;
    logic [TONE_W-1:0] half;
    logic [TONE_W-1:0] half_lut [16];

    switch_debouncer #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (sw),
        .cand  (cand),
        .commit(commit)
    );

    function automatic note_t encode(input logic [7:0] v);
        note_t code;
        code = NOTE_NONE;
`ifdef PIANO_CHORD_PRIORITY_EN
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) code = note_t'(i + 1);
        end
`else
        if ((v != 8'd0) && ((v & (v - 8'd1)) == 8'd0)) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) code = note_t'(i + 1);
            end
        end
`endif
        return code;
    endfunction

    // Constant table folded at elaboration; unused codes get a harmless 1.
    for (genvar g = 0; g < 16; g++) begin : g_half
        assign half_lut[g] = half_period(note_t'(g), TONE_SCALE);
    end

    assign enc    = encode(cand);
    assign change = commit && (enc != note);
    assign half   = half_lut[note];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            note        <= NOTE_NONE;
            note_strobe <= 1'b0;
        end else begin
            note_strobe <= change;
            if (commit) note <= enc;
        end
    end

    // A note change restarts the phase so the first rise is exactly half edges later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tcnt <= '0;
            FREQ <= 1'b0;
        end else if (change || (note == NOTE_NONE)) begin
            tcnt <= '0;
            FREQ <= 1'b0;
        end else if (tcnt == half - 1'b1) begin
            tcnt <= '0;
            FREQ <= ~FREQ;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_piano_keyboard.sv
// Randomised bench for piano_keyboard with a queue-based note/strobe scoreboard
// and a per-cycle tone reference computed from the half-period table.
module tb_piano_keyboard;

    localparam int D     = 4;
    localparam int SCALE = 1000;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] sw    = 8'h00;
    logic [3:0] note;
    logic       note_strobe;
    logic       FREQ;

    always #5 CLK = ~CLK;

    piano_keyboard #(
        .DEBOUNCE_CYCLES(D),
        .TONE_SCALE     (SCALE)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .sw         (sw),
        .note       (note),
        .note_strobe(note_strobe),
        .FREQ       (FREQ)
    );

    typedef struct {
        int code;
        int t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int cycle      = 0;
    int compared   = 0;
    int mismatched = 0;
    int model_note = 0;
    int cur_note   = 0;
    int cur_ts     = 0;
    logic [7:0] prev_sw = 8'h00;

    int half_tab [9] = '{0, 191110, 170265, 151685, 143172, 127551, 113636, 101239, 95557};

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic int enc_model(input logic [7:0] v);
        int n;
        int low;
        n   = 0;
        low = -1;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                n++;
                if (low < 0) low = i;
            end
        end
        if (n == 0) return 0;
        if (n == 1) return low + 1;
`ifdef PIANO_CHORD_PRIORITY_EN
        return low + 1;
`else
        return 0;
`endif
    endfunction

    function automatic int model_freq(input int t);
        int h;
        if (cur_note == 0) return 0;
        h = half_tab[cur_note] / SCALE;
        if (h < 1) h = 1;
        return ((t - cur_ts) / h) % 2;
    endfunction

    // Hold v for len cycles; a hold of at least D+1 samples commits D+4 cycles after the change.
    task automatic seg(input logic [7:0] v, input int len);
        int code;
        exp_t e;
        sw = v;
        if (len >= D + 1) begin
            code = enc_model(v);
            if (code != model_note) begin
                e.code = code;
                e.t    = cycle + D + 4;
                exp_q.push_back(e);
                model_note = code;
            end
        end
        prev_sw = v;
        repeat (len) @(negedge CLK);
    endtask

    // Monitor: pops an expectation whenever the DUT strobes; checks note and tone every cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                cur_note = 0;
                cur_ts   = 0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].t < cycle) begin
                    mon_e = exp_q.pop_front();
                    check("missed_strobe", 0, 1);
                    cur_note = mon_e.code;
                    cur_ts   = mon_e.t;
                end
                if (note_strobe) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("strobe_time", cycle, mon_e.t);
                        check("strobe_note", int'(note), mon_e.code);
                        cur_note = mon_e.code;
                        cur_ts   = mon_e.t;
                    end
                end
                check("note", int'(note), cur_note);
                check("freq", int'(FREQ), model_freq(cycle));
            end
        end
    end

    initial begin
        logic [7:0] v;
        int len;
        int r;
        int guard;

        #1;
        check("reset_note", int'(note), 0);
        check("reset_strobe", int'(note_strobe), 0);
        check("reset_freq", int'(FREQ), 0);
        @(negedge CLK);
        #2 RESET = 1'b0;
        @(negedge CLK);

        seg(8'h01, 500);
        seg(8'h02, 3);
        seg(8'h01, 30);
        seg(8'h80, 500);
        seg(8'h00, 50);
        seg(8'h14, 50);
        seg(8'h00, 30);
        seg(8'h04, 20);
        seg(8'h00, 20);
        seg(8'h04, 20);
        seg(8'h00, 20);
        seg(8'h08, 20);
        seg(8'h20, D);
        seg(8'h40, D + 1);
        seg(8'h20, 30);

        for (int k = 0; k < 80; k++) begin
            v = prev_sw;
            while (v == prev_sw) begin
                r = $urandom_range(0, 3);
                if (r == 0)      v = 8'h00;
                else if (r == 3) v = 8'($urandom_range(0, 255));
                else             v = 8'h01 << $urandom_range(0, 7);
            end
            if ($urandom_range(0, 2) == 0) len = $urandom_range(1, D);
            else                           len = $urandom_range(D + 1, 300);
            seg(v, len);
        end

        if (prev_sw == 8'h04) seg(8'h00, 30);
        seg(8'h04, 300);
        guard = 0;
        while (model_freq(cycle) == 0 && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        #2 RESET = 1'b1;
        #1;
        check("midreset_note", int'(note), 0);
        check("midreset_strobe", int'(note_strobe), 0);
        check("midreset_freq", int'(FREQ), 0);
        exp_q.delete();
        model_note = 0;
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b0;
        mon_e.code = 3;
        mon_e.t    = cycle + D + 4;
        exp_q.push_back(mon_e);
        model_note = 3;
        @(negedge CLK);
        repeat (400) @(negedge CLK);

        seg(8'h00, 50);
        check("pending_expectations", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piano_keyboard.md
Name: piano_keyboard

Overview:
- Front-end stage of the FPGA piano. Synchronises and debounces the 8 key switches, encodes them into a 4-bit note code, and generates the square-wave FREQ tone.
- Its note output feeds the song-guide FSMs, which advance on note / none alternation.
- A strobe marks every committed note change for downstream consumers.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a switch vector is committed (10 ms at 100 MHz); minimum 2.
- TONE_SCALE, 1, divisor applied to every half-period constant (simulation speed-up); result floored, minimum 1.

Ports:
- CLK  in  1  system clock, 100 MHz
- RESET  in  1  asynchronous, active-high reset
- sw  in  8  raw key switches; sw[0]=C4, sw[1]=D, sw[2]=E, sw[3]=F, sw[4]=G, sw[5]=A, sw[6]=B, sw[7]=C5
- note  out  4  committed note code: none=0, C4=1, D=2, E=3, F=4, G=5, A=6, B=7, C5=8
- note_strobe  out  1  one-cycle pulse on the edge where note changes value
- FREQ  out  1  square-wave tone; 0 while note==none

Behaviour:
- Reset is RESET, asynchronous, active-high; clock is CLK. All flops clear on RESET: note=0, note_strobe=0, FREQ=0, synchroniser/candidate/counters=0.
- Synchroniser: two flops, s1<=sw, s2<=s1.
- Debounce, per edge:
  - If s2!=cand: cand<=s2, dcnt<=0.
  - Else if dcnt==DEBOUNCE_CYCLES-1: commit, dcnt holds.
  - Else dcnt++.
- Commit writes note<=encode(cand) every hold cycle. note_strobe=1 only on the edge where the new code differs from the old.
- Latency: a change on sw held stable before edge 0 appears on note at edge DEBOUNCE_CYCLES+3, exactly. Any sw change mid-count restarts the count. Glitches shorter than DEBOUNCE_CYCLES never reach note.
- Encoding: exactly one switch high gives that note. Zero switches or two or more high give none (0).
- Tone generator:
  - Half-period table at 100 MHz: C4 191110, D 170265, E 151685, F 143172, G 127551, A 113636, B 101239, C5 95557.
  - half = table/TONE_SCALE.
  - 18-bit counter tcnt.
  - On a note_strobe edge: tcnt<=0, FREQ<=0.
  - Otherwise, if note!=none: when tcnt==half-1, FREQ toggles and tcnt<=0; else tcnt++.
  - If note==none: FREQ<=0, tcnt<=0.
  - Period is exactly 2*half cycles. The first FREQ rise occurs half edges after the strobe edge.
- Re-committing the same note produces no strobe and no phase reset.
- RESET mid-tone forces FREQ=0 immediately. After release, the note is re-acquired only via the full debounce latency.

Optional Feature:
- Macro: PIANO_CHORD_PRIORITY_EN.
- Defined: with two or more switches high, the lowest-index high switch wins (e.g. sw=0x14 gives E=3).
- Undefined: any multi-switch vector encodes none.
- Single-switch and all-zero behaviour is identical in both builds.

Decomposition:
- Package piano_pkg holds:
  - NOTE_W=4 and the note code constants none..C5.
  - The 8-entry half-period constant table and a function half_period(note, scale).
  - Shared with the song-guide FSMs so note codes stay consistent.
- One sub-module is natural: switch_debouncer, parameterised by WIDTH and DEBOUNCE_CYCLES. It contains the synchroniser, candidate register and stability counter, and outputs cand plus a commit pulse.
- Encoding and the tone generator stay in piano_keyboard.

Test Plan:
- Reset: with DEBOUNCE_CYCLES=4, TONE_SCALE=1000, assert RESET mid-sim with sw=0x04 -> note=0, FREQ=0, note_strobe=0 immediately; after release, note=3 exactly 7 edges later with a single strobe pulse.
- Debounce/latency: sw 0x00->0x01 -> note=1 at edge 7; a 3-cycle pulse sw=0x02 -> note unchanged, no strobe.
- Tone: note=C4 with TONE_SCALE=1000 (half=191) -> FREQ first rises 191 edges after the strobe; subsequent period 382 cycles at 50% duty. Switching to C5 (half=95) -> FREQ forced 0 on the strobe edge, then period 190.
- Release: sw->0x00 -> note=0 after 7 edges, strobe pulses, FREQ 0 from that edge on.
- Chord: sw=0x14 -> note=0 (macro undefined) or note=3 (PIANO_CHORD_PRIORITY_EN defined).
- Song sequence: drive E, none, E, none, F with 20-cycle gaps -> note sequence 3,0,3,0,4 with exactly five strobes; repeated E produces no extra strobe while held.
